// File: rtl/ps2_trx_core.sv
// ---------------------------------------------------------------------------
// ps2_trx_core
//
// PS/2 host transceiver core. Receives device frames into a small byte FIFO,
// transmits host bytes using the inhibit / request-to-send sequence, checks
// the device acknowledge, and aborts stalled frames with a watchdog. The pads
// are open-drain, so the core only ever asks for a line to be pulled low.
//
// Ports:
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   en_i                  core enable; low aborts any frame and frees lines
//   flush_i               synchronous RX FIFO clear
//   ps2_clk_i, ps2_dat_i  raw pad inputs (asynchronous to clk_i)
//   ps2_clk_oe_o          1 = pull PS/2 clock low
//   ps2_dat_oe_o          1 = pull PS/2 data low
//   rx_dat_o/valid/ready  FIFO head byte and pop handshake
//   rx_cnt_o              FIFO occupancy
//   tx_dat_i/valid/ready  transmit byte handshake
//   tx_done_o             pulse: transmit finished and device acked
//   tx_ack_err_o          pulse: device did not ack
//   rx_par_err_o          pulse: received frame failed odd parity
//   rx_frm_err_o          pulse: received stop bit was 0
//   rx_ovf_o              pulse: good frame dropped because FIFO full
//   timeout_o             pulse: watchdog fired mid-frame
//   busy_o                frame engine not idle
// ---------------------------------------------------------------------------
module ps2_trx_core #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic                             flush_i,
  input  logic                             ps2_clk_i,
  input  logic                             ps2_dat_i,
  output logic                             ps2_clk_oe_o,
  output logic                             ps2_dat_oe_o,
  output logic [7:0]                       rx_dat_o,
  output logic                             rx_valid_o,
  input  logic                             rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_cnt_o,
  input  logic [7:0]                       tx_dat_i,
  input  logic                             tx_valid_i,
  output logic                             tx_ready_o,
  output logic                             tx_done_o,
  output logic                             tx_ack_err_o,
  output logic                             rx_par_err_o,
  output logic                             rx_frm_err_o,
  output logic                             rx_ovf_o,
  output logic                             timeout_o,
  output logic                             busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYC - 1);
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYC - 2);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_INH,
    TX_DATA,
    TX_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   rx_par_q, rx_par_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   tx_par_q, tx_par_d;
  logic [INH_W-1:0]       inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   dat_oe_q, dat_oe_d;
  logic                   tx_done_q, tx_done_d;
  logic                   ack_err_q, ack_err_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   ovf_q, ovf_d;
  logic                   timeout_q, timeout_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             mem_q [FIFO_DEPTH];

  logic clk_s;
  logic dat_s;
  logic clk_fall;
  logic pop;
  logic push;
  logic fifo_full;
  logic tx_accept;

  // Synchronised pad levels; a falling edge is a high-then-low pair of the
  // synchronised clock on consecutive system cycles.
  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign clk_fall  = clk_prev_q & ~clk_s;

  assign pop       = (cnt_q != '0) && rx_ready_i;
  assign fifo_full = (cnt_q == CNT_FULL);

  // A transmit may only start while the bus is idle (clock released high).
  assign tx_ready_o = en_i && clk_s && (state_q == IDLE);
  assign tx_accept  = tx_ready_o && tx_valid_i;

  // Pad synchronisers shift the raw pins in and remember the last clock level.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
    clk_prev_d = clk_s;
  end

  // Frame engine next-state logic. Everything the FSM drives is computed here
  // and registered below, so the pad enables and pulses come straight from
  // flops. The watchdog only runs in states that wait on the device.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_par_d  = rx_par_q;
    tx_byte_d = tx_byte_q;
    tx_par_d  = tx_par_q;
    inh_cnt_d = inh_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    tx_done_d = 1'b0;
    ack_err_d = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    ovf_d     = 1'b0;
    timeout_d = 1'b0;
    push      = 1'b0;

    if (!en_i) begin
      state_d  = IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      wd_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          wd_cnt_d = '0;
          if (tx_accept) begin
            tx_byte_d = tx_dat_i;
            tx_par_d  = ~^tx_dat_i;
            inh_cnt_d = '0;
            clk_oe_d  = 1'b1;
            state_d   = TX_INH;
          end else if (clk_fall && !dat_s) begin
            bit_idx_d = 4'd1;
            state_d   = RX;
          end
        end

        RX: begin
          if (clk_fall) begin
            wd_cnt_d  = '0;
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q <= 4'd8) begin
              shift_d = {dat_s, shift_q[7:1]};
            end else if (bit_idx_q == 4'd9) begin
              rx_par_d = dat_s;
            end else begin
              state_d = IDLE;
              if (!dat_s) begin
                frm_err_d = 1'b1;
              end else if (!(^{shift_q, rx_par_q})) begin
                par_err_d = 1'b1;
              end else if (fifo_full && !pop) begin
                ovf_d = 1'b1;
              end else begin
                push = 1'b1;
              end
            end
          end else if (wd_cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            wd_cnt_d  = '0;
            state_d   = IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + TO_W'(1);
          end
        end

        TX_INH: begin
          clk_oe_d = 1'b1;
          if (inh_cnt_q == INH_START) begin
            dat_oe_d = 1'b1;
          end
          if (inh_cnt_q == INH_LAST) begin
            clk_oe_d  = 1'b0;
            bit_idx_d = 4'd0;
            wd_cnt_d  = '0;
            state_d   = TX_DATA;
          end else begin
            inh_cnt_d = inh_cnt_q + INH_W'(1);
          end
        end

        TX_DATA: begin
          if (clk_fall) begin
            wd_cnt_d  = '0;
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q < 4'd8) begin
              dat_oe_d = ~tx_byte_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              dat_oe_d = ~tx_par_q;
            end else begin
              dat_oe_d = 1'b0;
              state_d  = TX_ACK;
            end
          end else if (wd_cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b0;
            wd_cnt_d  = '0;
            state_d   = IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + TO_W'(1);
          end
        end

        TX_ACK: begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          if (clk_fall) begin
            wd_cnt_d = '0;
            state_d  = IDLE;
            if (!dat_s) begin
              tx_done_d = 1'b1;
            end else begin
              ack_err_d = 1'b1;
            end
          end else if (wd_cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            wd_cnt_d  = '0;
            state_d   = IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + TO_W'(1);
          end
        end

        default: begin
          state_d  = IDLE;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          wd_cnt_d = '0;
        end
      endcase
    end
  end

  // FIFO pointer and occupancy update. Flush wins over any push or pop in the
  // same cycle; a push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // All state lives here. Synchronisers reset to 1 so the core sees an idle
  // bus; reset also drops both pad enables immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_par_q   <= 1'b0;
      tx_byte_q  <= '0;
      tx_par_q   <= 1'b0;
      inh_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      ack_err_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      timeout_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_par_q   <= rx_par_d;
      tx_byte_q  <= tx_byte_d;
      tx_par_q   <= tx_par_d;
      inh_cnt_q  <= inh_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      tx_done_q  <= tx_done_d;
      ack_err_q  <= ack_err_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovf_q      <= ovf_d;
      timeout_q  <= timeout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      if (push && !flush_i) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
    end
  end

  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;
  assign rx_dat_o     = mem_q[rd_ptr_q];
  assign rx_valid_o   = (cnt_q != '0);
  assign rx_cnt_o     = cnt_q;
  assign tx_done_o    = tx_done_q;
  assign tx_ack_err_o = ack_err_q;
  assign rx_par_err_o = par_err_q;
  assign rx_frm_err_o = frm_err_q;
  assign rx_ovf_o     = ovf_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = (state_q != IDLE);

endmodule
